// File: rtl/lc3_mem_sequencer_if.sv
// lc3_mem_sequencer_if
// Bundles the request-side handshake and the SRAM pin bus of the LC-3
// memory sequencer.
//   Request side : Req, Wr, Addr, Wdata (to sequencer); Busy, Done, Rdata (from)
//   SRAM side    : Mem_CE_N, Mem_OE_N, Mem_WE_N, Mem_Addr, Data_to_SRAM (from
//                  sequencer); Data_from_SRAM (to sequencer)
// Modports:
//   slave  - the sequencer itself
//   master - whatever sits around it (datapath requester plus SRAM)
interface lc3_mem_sequencer_if;
  logic        Req;
  logic        Wr;
  logic [15:0] Addr;
  logic [15:0] Wdata;
  logic        Busy;
  logic        Done;
  logic [15:0] Rdata;
  logic        Mem_CE_N;
  logic        Mem_OE_N;
  logic        Mem_WE_N;
  logic [15:0] Mem_Addr;
  logic [15:0] Data_to_SRAM;
  logic [15:0] Data_from_SRAM;

  modport slave (
    input  Req, Wr, Addr, Wdata, Data_from_SRAM,
    output Busy, Done, Rdata, Mem_CE_N, Mem_OE_N, Mem_WE_N, Mem_Addr,
           Data_to_SRAM
  );

  modport master (
    output Req, Wr, Addr, Wdata, Data_from_SRAM,
    input  Busy, Done, Rdata, Mem_CE_N, Mem_OE_N, Mem_WE_N, Mem_Addr,
           Data_to_SRAM
  );
endinterface

// File: rtl/lc3_mem_sequencer.sv
// lc3_mem_sequencer
// Sequences one asynchronous SRAM access at a time for the LC-3 datapath.
// A request in IDLE latches MAR (and MDR for writes), then the block walks
// SETUP -> ACCESS (WAIT_CYCLES cycles) -> DONE -> IDLE. Read data is captured
// into MDR on the last ACCESS edge; Rdata always shows MDR.
// Ports:
//   Clk    - system clock, all state changes on the rising edge
//   Reset  - synchronous, active-high
//   bus    - request handshake and SRAM pins (slave modport)
// Parameter:
//   WAIT_CYCLES - cycles with strobes active in ACCESS, 1..15
module lc3_mem_sequencer #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic              Clk,
  input logic              Reset,
  lc3_mem_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: begin
        if (bus.Req) begin
          mar_d   = bus.Addr;
          wr_d    = bus.Wr;
          if (bus.Wr) mdr_d = bus.Wdata;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = CNT_LOAD;
        state_d = ACCESS;
      end
      ACCESS: begin
        // Counter reaching zero marks the last strobed edge; a read samples
        // the SRAM here, after OE_N has been low since SETUP.
        if (cnt_q == 4'd0) begin
          if (!wr_q) mdr_d = bus.Data_from_SRAM;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes depend only on registered state so they cannot glitch on inputs.
  always_comb begin
    bus.Busy     = (state_q != IDLE);
    bus.Done     = (state_q == DONE);
    bus.Mem_CE_N = (state_q == IDLE);
    bus.Mem_OE_N = !(!wr_q && ((state_q == SETUP) || (state_q == ACCESS)));
    bus.Mem_WE_N = !(wr_q && (state_q == ACCESS));
  end

  assign bus.Mem_Addr     = mar_q;
  assign bus.Data_to_SRAM = mdr_q;
  assign bus.Rdata        = mdr_q;

endmodule

// File: tb/tb_lc3_mem_sequencer.sv
// tb_lc3_mem_sequencer
// Drives three sequencer instances (WAIT_CYCLES = 1, 2, 15) sharing one clock
// and reset, each attached to its own behavioural SRAM. Expected per-cycle
// outputs come from a transaction-level model of the access timeline.
module tb_lc3_mem_sequencer;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  logic        req_v   [3];
  logic        wr_v    [3];
  logic [15:0] addr_v  [3];
  logic [15:0] wdata_v [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic        ce_v    [3];
  logic        oe_v    [3];
  logic        we_v    [3];
  logic [15:0] maddr_v [3];
  logic [15:0] dts_v   [3];
  logic [15:0] rdata_v [3];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference memory contents and expected MDR per instance.
  logic [15:0] ref_m [int];
  logic [15:0] mdr_m [3];

  function automatic int wl(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 2 : 15);
  endfunction

  // Power-up contents of the SRAMs; 0x3000 holds 0xBEEF in every instance.
  function automatic logic [15:0] init_val(input int g, input logic [15:0] a);
    if (a == 16'h3000) return 16'hBEEF;
    return a ^ 16'h5A5A ^ 16'(g * 16'h1111);
  endfunction

  function automatic logic [15:0] ref_rd(input int g, input logic [15:0] a);
    int key;
    key = g * 65536 + int'(a);
    if (ref_m.exists(key)) return ref_m[key];
    return init_val(g, a);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int unsigned WC = (g == 0) ? 1 : ((g == 1) ? 2 : 15);
    lc3_mem_sequencer_if ifc ();
    logic [15:0] mem     [0:65535];
    logic        written [0:65535];

    assign ifc.Req   = req_v[g];
    assign ifc.Wr    = wr_v[g];
    assign ifc.Addr  = addr_v[g];
    assign ifc.Wdata = wdata_v[g];
    assign ifc.Data_from_SRAM = (!ifc.Mem_CE_N && !ifc.Mem_OE_N) ?
        ((written[ifc.Mem_Addr] === 1'b1) ? mem[ifc.Mem_Addr] : init_val(g, ifc.Mem_Addr)) :
        16'hxxxx;

    always @(posedge Clk) begin
      if (!ifc.Mem_CE_N && !ifc.Mem_WE_N) begin
        mem[ifc.Mem_Addr]     <= ifc.Data_to_SRAM;
        written[ifc.Mem_Addr] <= 1'b1;
      end
    end

    assign busy_v[g]  = ifc.Busy;
    assign done_v[g]  = ifc.Done;
    assign ce_v[g]    = ifc.Mem_CE_N;
    assign oe_v[g]    = ifc.Mem_OE_N;
    assign we_v[g]    = ifc.Mem_WE_N;
    assign maddr_v[g] = ifc.Mem_Addr;
    assign dts_v[g]   = ifc.Data_to_SRAM;
    assign rdata_v[g] = ifc.Rdata;

    lc3_mem_sequencer #(.WAIT_CYCLES(WC)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (ifc.slave)
    );
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input int g, input string ctx,
                         input logic busy, input logic done, input logic ce,
                         input logic oe, input logic we, input logic [15:0] maddr,
                         input logic [15:0] mdr);
    chk({ctx, " busy"},  16'(busy_v[g]), 16'(busy));
    chk({ctx, " done"},  16'(done_v[g]), 16'(done));
    chk({ctx, " ce_n"},  16'(ce_v[g]),   16'(ce));
    chk({ctx, " oe_n"},  16'(oe_v[g]),   16'(oe));
    chk({ctx, " we_n"},  16'(we_v[g]),   16'(we));
    chk({ctx, " maddr"}, maddr_v[g],     maddr);
    chk({ctx, " dts"},   dts_v[g],       mdr);
    chk({ctx, " rdata"}, rdata_v[g],     mdr);
  endtask

  // One access on instance g. Entered at a falling edge in an IDLE cycle;
  // returns at the falling edge of the first IDLE cycle after Done. With
  // hold set, Req stays high and Addr switches to hold_addr mid-access so
  // the next call chains back-to-back.
  task automatic txn(input int g, input bit wr, input logic [15:0] a,
                     input logic [15:0] wd, input bit hold,
                     input logic [15:0] hold_addr);
    int          w;
    logic [15:0] rd_exp, prev, mdr_e;
    logic        e_busy, e_done, e_ce, e_oe, e_we;
    w      = wl(g);
    rd_exp = ref_rd(g, a);
    prev   = mdr_m[g];
    req_v[g]   = 1'b1;
    wr_v[g]    = wr;
    addr_v[g]  = a;
    wdata_v[g] = wd;
    @(posedge Clk);
    for (int k = 1; k <= w + 3; k++) begin
      @(negedge Clk);
      e_busy = (k <= w + 2);
      e_done = (k == w + 2);
      e_ce   = !(k <= w + 2);
      e_oe   = !(!wr && (k <= w + 1));
      e_we   = !(wr && (k >= 2) && (k <= w + 1));
      if (wr)              mdr_e = wd;
      else if (k >= w + 2) mdr_e = rd_exp;
      else                 mdr_e = prev;
      chk_all(g, $sformatf("g%0d %s a=%h k=%0d", g, wr ? "wr" : "rd", a, k),
              e_busy, e_done, e_ce, e_oe, e_we, a, mdr_e);
      if (hold) begin
        req_v[g] = 1'b1;
        wr_v[g]  = 1'b0;
        if (k >= 2) addr_v[g] = hold_addr;
      end else if (k <= w + 2) begin
        req_v[g]   = 1'($urandom_range(0, 1));
        wr_v[g]    = 1'($urandom_range(0, 1));
        addr_v[g]  = 16'($urandom);
        wdata_v[g] = 16'($urandom);
      end else begin
        req_v[g] = 1'b0;
      end
    end
    if (wr) begin
      ref_m[g * 65536 + int'(a)] = wd;
      mdr_m[g] = wd;
    end else begin
      mdr_m[g] = rd_exp;
    end
  endtask

  initial begin
    logic [15:0] ra, rw;
    int          rg;
    bit          rwr;
    for (int g = 0; g < 3; g++) begin
      req_v[g] = 1'b0; wr_v[g] = 1'b0; addr_v[g] = '0; wdata_v[g] = '0;
      mdr_m[g] = '0;
    end

    // Reset, then five idle cycles with everything at reset values.
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (5) @(negedge Clk);
    for (int g = 0; g < 3; g++)
      chk_all(g, $sformatf("g%0d reset", g), 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0, 16'h0);

    // WAIT_CYCLES=2 read of 0x3000 returning 0xBEEF, then a write.
    txn(1, 1'b0, 16'h3000, 16'h0000, 1'b0, 16'h0);
    txn(1, 1'b1, 16'h0010, 16'h1234, 1'b0, 16'h0);
    txn(1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0);

    // Req held through a read while Addr moves to 0x5555, then back-to-back.
    txn(1, 1'b0, 16'h3000, 16'h0000, 1'b1, 16'h5555);
    txn(1, 1'b0, 16'h5555, 16'h0000, 1'b0, 16'h0);

    // WAIT_CYCLES=1 and WAIT_CYCLES=15 reads.
    txn(0, 1'b0, 16'h3000, 16'h0000, 1'b0, 16'h0);
    txn(2, 1'b0, 16'h3000, 16'h0000, 1'b0, 16'h0);

    // Reset during ACCESS of a write on the WAIT_CYCLES=2 instance.
    req_v[1] = 1'b1; wr_v[1] = 1'b1; addr_v[1] = 16'h0020; wdata_v[1] = 16'h4321;
    @(posedge Clk);
    @(negedge Clk);
    req_v[1] = 1'b0;
    @(negedge Clk);
    chk("g1 mid-write we_n", 16'(we_v[1]), 16'h0);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    // The SRAM saw WE_N low for one cycle, so that location now holds the data.
    ref_m[1 * 65536 + 16'h0020] = 16'h4321;
    for (int g = 0; g < 3; g++) mdr_m[g] = '0;
    chk_all(1, "g1 after reset", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0, 16'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      chk("g1 no done after reset", 16'(done_v[1]), 16'h0);
    end

    // Random traffic across all three instances.
    for (int i = 0; i < 24; i++) begin
      rg  = int'($urandom_range(0, 2));
      rwr = 1'($urandom_range(0, 1));
      ra  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
      rw  = 16'($urandom);
      txn(rg, rwr, ra, rw, 1'b0, 16'h0);
    end
    for (int g = 0; g < 3; g++)
      for (int a = 0; a < 4; a++)
        txn(g, 1'b0, 16'(a), 16'h0, 1'b0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
